// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide over XLEN iterations, bracketed by an operand-latch edge and a sign-fix edge.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      MulDivOp,
  input  logic            Start,
  input  logic            Kill,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] MulDivResult
);

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t              state;
  logic [2:0]          op;
  logic                sign_a;
  logic                sign_b;
  logic                b_zero;
  logic [CNT_W-1:0]    cnt;
  logic [XLEN-1:0]     opa;
  logic [XLEN-1:0]     divisor;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN:0]       rem;
  logic [XLEN-1:0]     quo;

  logic signed [XLEN-1:0] srca_s;
  logic signed [XLEN-1:0] srcb_s;
  logic                   a_signed;
  logic                   b_signed;
  logic                   sign_a_in;
  logic                   sign_b_in;
  logic [XLEN-1:0]        abs_a;
  logic [XLEN-1:0]        abs_b;

  logic [XLEN:0]          mul_sum;
  logic [XLEN:0]          div_shift;
  logic [XLEN:0]          div_diff;

  logic [2*XLEN-1:0]      prod;
  logic [XLEN-1:0]        quo_fix;
  logic [XLEN-1:0]        rem_fix;
  logic [XLEN-1:0]        result;

  // Magnitude of a two's-complement word; the most negative value maps to itself,
  // which is its correct unsigned magnitude.
  function automatic logic [XLEN-1:0] abs_val(input logic signed [XLEN-1:0] v,
                                              input logic neg);
    abs_val = neg ? XLEN'(-v) : XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] neg_word(input logic [XLEN-1:0] v, input logic neg);
    neg_word = neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_dword(input logic [2*XLEN-1:0] v,
                                                  input logic neg);
    neg_dword = neg ? -v : v;
  endfunction

  // Operand decode at the latch edge
  always_comb begin
    srca_s   = SrcA;
    srcb_s   = SrcB;
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (MulDivOp)
      3'b001:  begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:  begin a_signed = 1'b1; b_signed = 1'b0; end
      3'b100:  begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b110:  begin a_signed = 1'b1; b_signed = 1'b1; end
      default: begin a_signed = 1'b0; b_signed = 1'b0; end
    endcase
    sign_a_in = a_signed & SrcA[XLEN-1];
    sign_b_in = b_signed & SrcB[XLEN-1];
    abs_a     = abs_val(srca_s, sign_a_in);
    abs_b     = abs_val(srcb_s, sign_b_in);
  end

  // One iteration: multiply and divide datapaths both step; the op selects at the end
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opa} : {(XLEN+1){1'b0}});
    div_shift = (rem << 1) | {{XLEN{1'b0}}, quo[XLEN-1]};
    div_diff  = div_shift - {1'b0, divisor};
  end

  // Sign correction and result selection
  always_comb begin
    prod    = neg_dword(acc, sign_a ^ sign_b);
    quo_fix = b_zero ? {XLEN{1'b1}} : neg_word(quo, sign_a ^ sign_b);
    rem_fix = neg_word(rem[XLEN-1:0], sign_a);
    case (op)
      3'b000:                 result = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = quo_fix;
      default:                result = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      op           <= '0;
      sign_a       <= 1'b0;
      sign_b       <= 1'b0;
      b_zero       <= 1'b0;
      cnt          <= '0;
      opa          <= '0;
      divisor      <= '0;
      acc          <= '0;
      rem          <= '0;
      quo          <= '0;
      Busy         <= 1'b0;
      Done         <= 1'b0;
      MulDivResult <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start && !Kill) begin
            op      <= MulDivOp;
            sign_a  <= sign_a_in;
            sign_b  <= sign_b_in;
            b_zero  <= (SrcB == '0);
            cnt     <= '0;
            opa     <= abs_a;
            divisor <= abs_b;
            acc     <= {{XLEN{1'b0}}, abs_b};
            rem     <= '0;
            quo     <= abs_a;
            Busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (Kill) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= {mul_sum, acc[XLEN-1:1]};
            rem <= div_diff[XLEN] ? div_shift : div_diff;
            quo <= {quo[XLEN-2:0], ~div_diff[XLEN]};
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN-1)) state <= FIX;
          end
        end
        FIX: begin
          Busy  <= 1'b0;
          state <= IDLE;
          if (!Kill) begin
            MulDivResult <= result;
            Done         <= 1'b1;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M corner cases plus random ops
// against an arithmetic reference model; a negedge monitor checks every Done.
module tb_muldiv_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic [2:0]      MulDivOp;
  logic            Start;
  logic            Kill;
  logic            Busy;
  logic            Done;
  logic [XLEN-1:0] MulDivResult;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .SrcA         (SrcA),
    .SrcB         (SrcB),
    .MulDivOp     (MulDivOp),
    .Start        (Start),
    .Kill         (Kill),
    .Busy         (Busy),
    .Done         (Done),
    .MulDivResult (MulDivResult)
  );

  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;
  logic [31:0] last_result;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_done  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RV32M semantics computed with 64-bit integer arithmetic
  function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (op)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  always @(negedge clk) begin
    if (Done === 1'b1) begin
      n_done++;
      check("busy_with_done", 32'(Busy), 32'd0);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got result %h expected no Done", MulDivResult);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", MulDivResult, mon_exp);
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [31:0] exp, input bit push, input bit hold_start);
    SrcA     = a;
    SrcB     = b;
    MulDivOp = op;
    Start    = 1'b1;
    if (push) begin
      exp_q.push_back(exp);
      last_result = exp;
    end
    @(posedge clk); #1;
    check("busy_after_start", 32'(Busy), 32'd1);
    check("done_low_after_start", 32'(Done), 32'd0);
    if (!hold_start) Start = 1'b0;
    SrcA     = $urandom;
    SrcB     = $urandom;
    MulDivOp = 3'($urandom);
  endtask

  task automatic wait_done(output int cyc, output int busy_n);
    cyc    = 0;
    busy_n = 1;
    while (Done !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      if (Busy === 1'b1) busy_n++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [31:0] exp);
    int cyc, busy_n;
    issue(a, b, op, exp, 1'b1, 1'b0);
    wait_done(cyc, busy_n);
    check("latency", 32'(cyc), 32'd33);
    check("busy_cycles", 32'(busy_n), 32'd33);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] d_a[13] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                           32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                           32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b[13] = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                           32'd2, 32'd2, 32'd7, 32'd7,
                           32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
  logic [2:0]  d_op[13] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                            3'd4, 3'd6, 3'd4, 3'd6, 3'd1};
  logic [31:0] d_exp[13] = '{32'h0000_002A, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                             32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                             32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0, 32'h4000_0000};

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc, busy_n, dn;
    logic [31:0] ra, rb;
    logic [2:0]  rop;

    reset_n     = 1'b0;
    Start       = 1'b0;
    Kill        = 1'b0;
    SrcA        = '0;
    SrcB        = '0;
    MulDivOp    = '0;
    last_result = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_done", 32'(Done), 32'd0);
    check("reset_result", MulDivResult, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, issued back-to-back in each Done cycle
    for (int i = 0; i < 13; i++) run_op(d_a[i], d_b[i], d_op[i], d_exp[i]);
    repeat (3) @(posedge clk);
    #1;

    // Start held high through the whole operation
    dn = n_done;
    issue(32'd1234, 32'd56, 3'd5, 32'd22, 1'b1, 1'b1);
    wait_done(cyc, busy_n);
    Start = 1'b0;
    check("hold_latency", 32'(cyc), 32'd33);
    repeat (40) @(posedge clk);
    #1;
    check("hold_one_done", 32'(n_done - dn), 32'd1);

    // Kill in the tenth RUN cycle
    dn = n_done;
    issue(32'd1000, 32'd3, 3'd4, 32'd0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    Kill = 1'b1;
    @(posedge clk); #1;
    Kill = 1'b0;
    check("kill_busy", 32'(Busy), 32'd0);
    check("kill_result_kept", MulDivResult, last_result);
    repeat (40) @(posedge clk);
    #1;
    check("kill_no_done", 32'(n_done - dn), 32'd0);
    check("kill_result_still", MulDivResult, last_result);

    // Asynchronous reset in the middle of a divide
    dn = n_done;
    issue(32'hFFFF_0000, 32'd9, 3'd4, 32'd0, 1'b0, 1'b0);
    repeat (14) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_busy", 32'(Busy), 32'd0);
    check("arst_done", 32'(Done), 32'd0);
    check("arst_result", MulDivResult, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("arst_no_done", 32'(n_done - dn), 32'd0);
    run_op(32'd3, 32'd4, 3'd0, 32'h0000_000C);

    // Random operations against the reference model
    for (int i = 0; i < 150; i++) begin
      ra  = pick_operand();
      rb  = pick_operand();
      rop = 3'($urandom);
      run_op(ra, rb, rop, ref_model(ra, rb, rop));
    end
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit; sits beside the alu and feeds the writeback result mux.
- Takes the same SrcA/SrcB operands as the alu and performs MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU over 33 cycles.
- Uses a Start/Busy/Done handshake; the control unit stalls the PC while Busy is high.

Parameters:
- XLEN, 32: operand and result width. The iteration count equals XLEN.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- SrcA  input  XLEN  operand A (multiplicand or dividend).
- SrcB  input  XLEN  operand B (multiplier or divisor).
- MulDivOp  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Start  input  1  request; sampled only in IDLE.
- Kill  input  1  synchronous abort (pipeline flush).
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse when MulDivResult is valid.
- MulDivResult  output  XLEN  result; held until the next Done.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE.
  - Busy=0, Done=0, MulDivResult=0.
  - All internal registers are cleared.
  - An in-flight operation is discarded.
- States: IDLE, RUN, FIX.
- IDLE:
  - If Start=1 at edge E0, latch SrcA, SrcB and MulDivOp.
  - Record operand signs per op: A signed for MULH/MULHSU/DIV/REM; B signed for MULH/DIV/REM.
  - Load the absolute values into the working registers, clear the 6-bit counter, go to RUN, set Busy=1.
  - If Start=0, stay in IDLE.
- RUN:
  - One iteration per edge, E1..E32. Counter increments each edge.
  - Multiply: radix-2 shift-add on a 2*XLEN accumulator.
  - Divide: restoring division. The remainder register is XLEN+1 bits (keeps the trial-subtract borrow); the quotient shifts in one bit per edge.
  - At E32 (counter = XLEN-1), go to FIX.
- FIX (edge E33):
  - Apply sign correction:
    - product negated if signA^signB;
    - quotient negated if signA^signB;
    - remainder takes the sign of A.
  - Select the result: low word for MUL; high word for MULH/MULHSU/MULHU; quotient for DIV/DIVU; remainder for REM/REMU.
  - Register it to MulDivResult, set Done=1 for exactly one cycle, set Busy=0, go to IDLE.
- Latency:
  - Busy is high for exactly 33 cycles (E0 to E33).
  - Done is visible in the cycle following E33.
  - Latency is fixed for all ops and operands, with no early termination.
- Back-to-back: Start=1 in the Done cycle is accepted. Done drops at that edge and Busy rises.
- Start while Busy=1 is ignored; the latched operands are unaffected.
- Operand changes on SrcA/SrcB/MulDivOp after E0 have no effect.
- Divide by zero (B=0), no trap:
  - DIV/DIVU result = all ones.
  - REM/REMU result = A.
  - Same 33-cycle latency.
- Signed overflow (DIV/REM, A=0x80000000, B=0xFFFFFFFF):
  - DIV result = 0x80000000.
  - REM result = 0.
- Absolute value of 0x80000000 is 0x80000000 treated as unsigned. This must produce correct MULH/MULHSU results.
- Kill:
  - Kill=1 in RUN or FIX sends state to IDLE at that edge.
  - Busy=0 after the edge; Done is not asserted; MulDivResult keeps its previous value.
  - Kill has priority over Start. Kill in IDLE has no effect.
- Reset mid-operation: as reset above. After reset_n rises, the first edge with Start=1 begins a fresh operation.
- Done and Busy are never high together.

Test Plan:
- Latency/MUL: A=7, B=6, op=000, Start pulse → Busy high 33 cycles, Done one cycle, MulDivResult=0x0000002A.
- High-word variants (A=0xFFFFFFFF, B=0xFFFFFFFF):
  - MULH → 0x00000000
  - MULHU → 0xFFFFFFFE
  - MULHSU → 0xFFFFFFFF
- Division signs:
  - DIV -7/2 (A=0xFFFFFFF9, B=2) → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100/7 → 14; REMU 100/7 → 2.
- Corner cases:
  - DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
  - MULH 0x80000000*0x80000000 → 0x40000000.
- Handshake:
  - Start=1 held while Busy → exactly one Done per accepted Start.
  - Kill at cycle 10 of RUN → Busy=0 next cycle, no Done, MulDivResult unchanged from prior op.
  - Start in Done cycle → new op accepted, Done again 33 cycles later.
- Reset: reset_n=0 asynchronously at cycle 15 of a DIV → Busy/Done/MulDivResult=0 immediately, no Done after release. A new MUL 3*4 then returns 0x0000000C.
